fifo_stream_reader: RTL and testbench
=====================================

// Module: fifo_stream_reader
// PURPOSE
//  Reader end for a synchronous FIFO with registered read data. Drives FIFO pop from the FIFO's empty flag.
//  Returns popped words on a downstream valid/ready stream at full throughput. Hides the FIFO read latency.
//  A small prefetch buffer absorbs the latency, so no word is lost or duplicated under backpressure.
//  Sits between a SyncFIFO-style queue and a stream consumer (decode/issue stage). Supports pipeline flush.
// PARAMETERS
//  DATA_WIDTH    32  width of FIFO word and stream payload
//  READ_LATENCY  1   cycles from pop (cycle t) to data valid on fifo_data_i (cycle t+READ_LATENCY); legal 1..2
//  BUF_DEPTH     localparam = READ_LATENCY+1; prefetch buffer entries (minimum for 1 word/cycle)
//  CNT_WIDTH     localparam = $clog2(BUF_DEPTH+1)
// PORTS
//  clk                 in   1           clock; all logic on rising edge
//  rst                 in   1           synchronous, active-high reset
//  flush_i             in   1           discard buffered and in-flight words
//  fifo_empty_i        in   1           FIFO empty flag
//  fifo_pop_o          out  1           FIFO pop request
//  fifo_data_i         in   DATA_WIDTH  FIFO read data, valid READ_LATENCY cycles after pop
//  m_valid_o           out  1           stream valid
//  m_ready_i           in   1           stream ready
//  m_data_o            out  DATA_WIDTH  stream payload = buffer head
//  occ_o               out  CNT_WIDTH   words held in prefetch buffer
//  perf_stall_cnt_o    out  32          cycles with m_valid_o & ~m_ready_i (see CONFIGURATION)
//  perf_starve_cnt_o   out  32          cycles with ~m_valid_o & m_ready_i (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=1 at clk edge): fifo_pop_o=0, m_valid_o=0, m_data_o=0, occ_o=0, in-flight tracker cleared, perf counters=0.
//  State:
//   - occ_q: buffer count, 0..BUF_DEPTH.
//   - infl_q: pops not yet returned, 0..READ_LATENCY.
//   - tag shift register, READ_LATENCY bits: bit0 <= fifo_pop_o; a set bit at the tail marks fifo_data_i as valid this cycle.
//   - circular buffer: rd_ptr/wr_ptr, BUF_DEPTH entries; pointers wrap BUF_DEPTH-1 -> 0 (non-power-of-2 safe).
//  fire = m_valid_o & m_ready_i.
//  fifo_pop_o = ~rst & ~flush_i & ~fifo_empty_i & (occ_q + infl_q < BUF_DEPTH + fire). Combinational.
//  Capture: when the tail tag is set, write fifo_data_i at wr_ptr.
//   - A capture and a fire in the same cycle leave occ unchanged.
//   - Occupancy never exceeds BUF_DEPTH; overflow is a design error, so assert it.
//  m_valid_o = (occ_q != 0); m_data_o = buf[rd_ptr]. Registered, so there is no fifo_data_i -> m_data_o path.
//  Stream rule: after m_valid_o rises, m_valid_o and m_data_o hold stable until fire.
//  Latency: pop at cycle t -> word on m_data_o with m_valid_o=1 at t+READ_LATENCY+1 (buffer initially empty).
//  Throughput: FIFO never empty and m_ready_i=1 -> fifo_pop_o and m_valid_o high every cycle in steady state.
//  Empty: fifo_empty_i=1 -> no pop; buffered words keep draining.
//  Flush at edge: buffer, pointers, occ, infl and tag register cleared. Words returning in later cycles are dropped.
//   - fifo_pop_o=0 during flush. m_valid_o=0 the next cycle. flush_i has priority over capture and fire.
//  Reset mid-transfer: identical to flush, plus perf counters clear. In-flight FIFO data after reset is ignored.
// CONFIGURATION
//  FIFO_READER_PERF_EN defined:
//   - perf_stall_cnt_o and perf_starve_cnt_o count as described above.
//   - Counters saturate at 32'hFFFF_FFFF, are cleared only by rst, and are unaffected by flush_i.
//  FIFO_READER_PERF_EN undefined: both perf ports tied to 32'h0; no counter flops.
// TESTING
//  1 Reset: rst=1 for 2 cycles with fifo_empty_i=0 -> fifo_pop_o=0, m_valid_o=0, occ_o=0, m_data_o=0.
//  2 Stream, L=1: FIFO holds 0..7, m_ready_i=1, pop first at cycle 0
//    -> fifo_pop_o high cycles 0..7; m_data_o=0..7 valid cycles 2..9, no gaps.
//  3 Backpressure, L=1: m_ready_i=0 from start -> exactly 2 pops, occ_o=2, m_data_o=0 stable;
//    ready=1 -> 0,1,2.. in order, no loss or duplicates.
//  4 Bubbles: fifo_empty_i toggles every other cycle, m_ready_i=1 -> no pop while empty; output order 0..N intact.
//  5 Flush, L=2: flush_i with occ_o=2 and infl=1 -> next cycle m_valid_o=0, occ_o=0;
//    returning word dropped; next pop delivers next FIFO word.
//  6 Perf: m_valid_o=1 with m_ready_i=0 for 5 cycles -> perf_stall_cnt_o=5 with FIFO_READER_PERF_EN, 0 without.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader
//
// Purpose:
//   Reader side of a synchronous FIFO whose read data arrives READ_LATENCY
//   cycles after the pop. Pops are issued from the FIFO empty flag and from the
//   room left in a small prefetch buffer. The words are returned on a
//   valid/ready stream at one word per cycle. Because the buffer has
//   READ_LATENCY+1 entries, every word already in flight always has a slot,
//   even while the consumer applies backpressure.
//
// Ports:
//   clk                in   clock, rising edge
//   rst                in   synchronous active-high reset
//   flush_i            in   drop buffered and in-flight words
//   fifo_empty_i       in   FIFO empty flag
//   fifo_pop_o         out  FIFO pop request (combinational)
//   fifo_data_i        in   FIFO read data, valid READ_LATENCY cycles after pop
//   m_valid_o          out  stream valid (buffer not empty)
//   m_ready_i          in   stream ready
//   m_data_o           out  stream payload, taken from the buffer head register
//   occ_o              out  number of words held in the prefetch buffer
//   perf_stall_cnt_o   out  cycles with valid and not ready
//   perf_starve_cnt_o  out  cycles with ready and not valid
//
// Optional feature macro: FIFO_READER_PERF_EN
//   Defined   : the two perf counters are built. They saturate and are
//               cleared only by rst.
//   Undefined : both perf outputs are tied to zero and no counter flops exist.
// ---------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter  int DATA_WIDTH   = 32,
    parameter  int READ_LATENCY = 1,
    localparam int BUF_DEPTH    = READ_LATENCY + 1,
    localparam int CNT_WIDTH    = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_pop_o,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic [CNT_WIDTH-1:0]  occ_o,
    output logic [31:0]           perf_stall_cnt_o,
    output logic [31:0]           perf_starve_cnt_o
);

    localparam int PTR_WIDTH = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int SUM_WIDTH = CNT_WIDTH + 1;

    logic [DATA_WIDTH-1:0]   r_buf [BUF_DEPTH];
    logic [PTR_WIDTH-1:0]    r_rdPtr;
    logic [PTR_WIDTH-1:0]    r_wrPtr;
    logic [CNT_WIDTH-1:0]    r_occ;
    logic [CNT_WIDTH-1:0]    r_infl;
    logic [READ_LATENCY-1:0] r_tag;

    logic                    w_fire;
    logic                    w_capture;
    logic                    w_pop;
    logic [SUM_WIDTH-1:0]    w_pending;
    logic [SUM_WIDTH-1:0]    w_limit;
    logic [CNT_WIDTH-1:0]    w_occNext;
    logic [CNT_WIDTH-1:0]    w_inflNext;
    logic [READ_LATENCY-1:0] w_tagNext;

    // The buffer depth need not be a power of two (READ_LATENCY=2 gives three
    // entries), so the pointers wrap explicitly instead of by overflow.
    function automatic logic [PTR_WIDTH-1:0] nextPtr(input logic [PTR_WIDTH-1:0] p);
        if (p == PTR_WIDTH'(BUF_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_WIDTH'(1);
    endfunction

    // Stream side. The head entry is a register, so the payload never sees
    // a combinational path from fifo_data_i.
    assign m_valid_o = (r_occ != '0);
    assign m_data_o  = r_buf[r_rdPtr];
    assign occ_o     = r_occ;
    assign w_fire    = m_valid_o & m_ready_i;

    // The oldest tag bit marks the cycle in which the FIFO is driving the
    // word for a pop issued READ_LATENCY cycles earlier.
    assign w_capture = r_tag[READ_LATENCY-1];

    // A pop is allowed only if every word already owed to the buffer, plus
    // this new one, will have a slot. A word leaving this cycle frees one
    // slot early, which is what keeps full throughput in steady state.
    assign w_pending  = SUM_WIDTH'(r_occ) + SUM_WIDTH'(r_infl);
    assign w_limit    = SUM_WIDTH'(BUF_DEPTH) + SUM_WIDTH'(w_fire);
    assign w_pop      = ~rst & ~flush_i & ~fifo_empty_i & (w_pending < w_limit);
    assign fifo_pop_o = w_pop;

    // Next values of the tag shift register and of the two counters. New
    // pops enter at bit 0. A capture together with a fire leaves the
    // occupancy unchanged.
    always_comb begin
        w_tagNext    = '0;
        w_tagNext[0] = w_pop;
        for (int i = 1; i < READ_LATENCY; i++) begin
            w_tagNext[i] = r_tag[i-1];
        end

        w_occNext = r_occ;
        case ({w_capture, w_fire})
            2'b10:   w_occNext = r_occ + CNT_WIDTH'(1);
            2'b01:   w_occNext = r_occ - CNT_WIDTH'(1);
            default: w_occNext = r_occ;
        endcase

        w_inflNext = r_infl;
        case ({w_pop, w_capture})
            2'b10:   w_inflNext = r_infl + CNT_WIDTH'(1);
            2'b01:   w_inflNext = r_infl - CNT_WIDTH'(1);
            default: w_inflNext = r_infl;
        endcase
    end

    // Buffer, pointers and tracking state. Reset and flush both drop every
    // word in the buffer and forget every outstanding pop. Clearing the tags
    // is what makes words that return later be ignored.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_occ   <= '0;
            r_infl  <= '0;
            r_tag   <= '0;
        end else begin
            r_tag  <= w_tagNext;
            r_occ  <= w_occNext;
            r_infl <= w_inflNext;
            if (w_capture) begin
                r_buf[r_wrPtr] <= fifo_data_i;
                r_wrPtr        <= nextPtr(r_wrPtr);
            end
            if (w_fire) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
        end
    end

    // A capture into a full buffer with no word leaving would overwrite the
    // head. The pop gating above must make this impossible.
    assert property (@(posedge clk) disable iff (rst || flush_i)
        !(w_capture && !w_fire && (r_occ == CNT_WIDTH'(BUF_DEPTH))));

`ifdef FIFO_READER_PERF_EN
    logic [31:0] r_stallCnt;
    logic [31:0] r_starveCnt;

    // Stall and starve counters. They saturate at all-ones and ignore
    // flush_i, so a flush does not erase the history of a run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCnt  <= '0;
            r_starveCnt <= '0;
        end else begin
            if (m_valid_o && !m_ready_i && (r_stallCnt != '1)) begin
                r_stallCnt <= r_stallCnt + 32'd1;
            end
            if (!m_valid_o && m_ready_i && (r_starveCnt != '1)) begin
                r_starveCnt <= r_starveCnt + 32'd1;
            end
        end
    end

    assign perf_stall_cnt_o  = r_stallCnt;
    assign perf_starve_cnt_o = r_starveCnt;
`else
    assign perf_stall_cnt_o  = 32'h0;
    assign perf_starve_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_stream_reader
//
// Two readers run side by side: lane 0 with READ_LATENCY=1 and lane 1 with
// READ_LATENCY=2. The bench owns a FIFO for each lane and a scoreboard of the
// words each lane owes its consumer. Each word carries the cycle in which it
// must first appear on the stream. A pop at cycle t yields a word due at
// t+L+1. Flush and reset erase what is owed.
// ---------------------------------------------------------------------------
module tb_fifo_stream_reader;

   localparam int DW = 32;

   logic          clk;
   logic          rstS;
   logic          flushS   [2];
   logic          emptyS   [2];
   logic          readyS   [2];
   logic [DW-1:0] fdata    [2];
   logic          popO     [2];
   logic          validO   [2];
   logic [DW-1:0] dataO    [2];
   logic [1:0]    occO     [2];
   logic [31:0]   stallO   [2];
   logic [31:0]   starveO  [2];

   int            checks;
   int            errors;
   int            cyc;
   bit            checkEn;

   logic          holdEmpty [2];
   logic [31:0]   fifoMem   [2][256];
   int            fifoWr    [2];
   int            fifoRd    [2];

   logic [31:0]   sbWord    [2][16];
   int            sbDue     [2][16];
   int            sbHead    [2];
   int            sbCount   [2];

   logic          h1v [2];
   logic          h2v [2];
   logic [31:0]   h1w [2];
   logic [31:0]   h2w [2];

   logic [31:0]   expStall  [2];
   logic [31:0]   expStarve [2];
   logic          prevHold  [2];
   logic [31:0]   prevData  [2];

   // Both readers share the clock and the reset; every other input is per lane.
   for (genvar g = 0; g < 2; g++) begin : gLane
      fifo_stream_reader #(
         .DATA_WIDTH   (DW),
         .READ_LATENCY (g + 1)
      ) uDut (
         .clk               (clk),
         .rst               (rstS),
         .flush_i           (flushS[g]),
         .fifo_empty_i      (emptyS[g]),
         .fifo_pop_o        (popO[g]),
         .fifo_data_i       (fdata[g]),
         .m_valid_o         (validO[g]),
         .m_ready_i         (readyS[g]),
         .m_data_o          (dataO[g]),
         .occ_o             (occO[g]),
         .perf_stall_cnt_o  (stallO[g]),
         .perf_starve_cnt_o (starveO[g])
      );
   end

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one value and report it if it differs from what was expected.
   task automatic checkOutput(input string name, input int lane,
                              input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s lane%0d cycle %0d: got %h expected %h",
                  name, lane, cyc, act, exp);
      end
   endtask

   // The empty flag follows the FIFO contents, unless a bubble forces it high.
   task automatic updateEmpty();
      for (int l = 0; l < 2; l++) begin
         emptyS[l] = holdEmpty[l] || (fifoRd[l] == fifoWr[l]);
      end
   endtask

   // Drive one cycle's inputs. Bit l of each vector belongs to lane l.
   task automatic applyStimulus(input logic r, input logic [1:0] fl,
                                input logic [1:0] he, input logic [1:0] rdy);
      rstS = r;
      for (int l = 0; l < 2; l++) begin
         flushS[l]    = fl[l];
         holdEmpty[l] = he[l];
         readyS[l]    = rdy[l];
      end
      updateEmpty();
   endtask

   // Load consecutive words into a lane's FIFO.
   task automatic fillFifo(input int l, input logic [31:0] first, input int n);
      for (int k = 0; k < n; k++) begin
         fifoMem[l][fifoWr[l] % 256] = first + 32'(k);
         fifoWr[l]++;
      end
      updateEmpty();
   endtask

   // Per-cycle check of both lanes against the scoreboard, then advance the
   // scoreboard and the bench FIFOs by one cycle. It runs at the falling edge.
   // The FIFO data it sets is the word captured at the coming rising edge,
   // i.e. the word popped L cycles before the current one.
   task automatic modelStep();
      int          occE;
      logic        validE;
      logic        fireE;
      logic        popE;
      logic [31:0] word;
      for (int l = 0; l < 2; l++) begin
         occE = 0;
         for (int k = 0; k < sbCount[l]; k++) begin
            if (sbDue[l][(sbHead[l] + k) % 16] <= cyc) occE++;
         end
         validE = (occE != 0);
         fireE  = validE && readyS[l];
         popE   = !rstS && !flushS[l] && !emptyS[l] &&
                  (sbCount[l] < (l + 2) + (fireE ? 1 : 0));
         if (checkEn) begin
            checkOutput("valid", l, 32'(validO[l]), 32'(validE));
            checkOutput("occ", l, 32'(occO[l]), 32'(occE));
            if (validE) checkOutput("data", l, dataO[l], sbWord[l][sbHead[l]]);
            checkOutput("pop", l, 32'(popO[l]), 32'(popE));
`ifdef FIFO_READER_PERF_EN
            checkOutput("stall_cnt", l, stallO[l], expStall[l]);
            checkOutput("starve_cnt", l, starveO[l], expStarve[l]);
`else
            checkOutput("stall_cnt", l, stallO[l], 32'h0);
            checkOutput("starve_cnt", l, starveO[l], 32'h0);
`endif
            if (prevHold[l]) begin
               checkOutput("hold_valid", l, 32'(validO[l]), 32'h1);
               checkOutput("hold_data", l, dataO[l], prevData[l]);
            end
         end

         prevHold[l] = validE && !readyS[l] && !rstS && !flushS[l];
         prevData[l] = dataO[l];

         if (rstS) begin
            expStall[l]  = 32'h0;
            expStarve[l] = 32'h0;
         end else begin
            if (validE && !readyS[l] && expStall[l] != 32'hFFFF_FFFF) expStall[l]++;
            if (!validE && readyS[l] && expStarve[l] != 32'hFFFF_FFFF) expStarve[l]++;
         end

         if (rstS || flushS[l]) begin
            sbCount[l] = 0;
            sbHead[l]  = 0;
         end else if (fireE) begin
            sbHead[l]  = (sbHead[l] + 1) % 16;
            sbCount[l] = sbCount[l] - 1;
         end

         word = 32'hBAD0_0000 + 32'(cyc);
         if (popO[l] === 1'b1) begin
            word = fifoMem[l][fifoRd[l] % 256];
            fifoRd[l]++;
            if (!rstS && !flushS[l] && sbCount[l] < 16) begin
               sbWord[l][(sbHead[l] + sbCount[l]) % 16] = word;
               sbDue[l][(sbHead[l] + sbCount[l]) % 16]  = cyc + l + 2;
               sbCount[l]++;
            end
         end

         if (l == 0) fdata[l] = h1v[l] ? h1w[l] : 32'hBAD0_0000 + 32'(cyc);
         else        fdata[l] = h2v[l] ? h2w[l] : 32'hBAD0_0000 + 32'(cyc);
         h2v[l] = h1v[l];
         h2w[l] = h1w[l];
         h1v[l] = (popO[l] === 1'b1);
         h1w[l] = word;
      end
      cyc++;
      if (rstS) checkEn = 1'b1;
   endtask

   // Advance to one rising edge plus 1: model step at the falling edge,
   // then the empty flags update after the rising edge.
   task automatic nextCycle();
      @(negedge clk);
      modelStep();
      @(posedge clk);
      #1;
      updateEmpty();
   endtask

   task automatic doReset();
      applyStimulus(1'b1, 2'b00, 2'b00, 2'b11);
      nextCycle();
   endtask

   int pops;
   int k;

   initial begin
      checks  = 0;
      errors  = 0;
      cyc     = 0;
      checkEn = 1'b0;
      for (int l = 0; l < 2; l++) begin
         fifoWr[l] = 0; fifoRd[l] = 0; sbHead[l] = 0; sbCount[l] = 0;
         h1v[l] = 1'b0; h2v[l] = 1'b0; h1w[l] = '0; h2w[l] = '0;
         expStall[l] = '0; expStarve[l] = '0; prevHold[l] = 1'b0; prevData[l] = '0;
         fdata[l] = '0;
      end

      // Reset held for two cycles while lane 0's FIFO is not empty.
      fillFifo(0, 32'd0, 8);
      applyStimulus(1'b1, 2'b00, 2'b00, 2'b11);
      @(posedge clk);
      #1;
      for (int r = 0; r < 2; r++) begin
         checkOutput("rst_pop", 0, 32'(popO[0]), 32'h0);
         checkOutput("rst_valid", 0, 32'(validO[0]), 32'h0);
         checkOutput("rst_occ", 0, 32'(occO[0]), 32'h0);
         checkOutput("rst_data", 0, dataO[0], 32'h0);
         nextCycle();
      end

      // Lane 0 streams 0..7. It pops in cycles 0..7 and the words are valid
      // in cycles 2..9.
      applyStimulus(1'b0, 2'b00, 2'b00, 2'b11);
      for (int c = 0; c < 12; c++) begin
         #1;
         checkOutput("t2_pop", 0, 32'(popO[0]), (c < 8) ? 32'h1 : 32'h0);
         checkOutput("t2_valid", 0, 32'(validO[0]), (c >= 2 && c <= 9) ? 32'h1 : 32'h0);
         if (c >= 2 && c <= 9) checkOutput("t2_data", 0, dataO[0], 32'(c - 2));
         nextCycle();
      end

      // Backpressure from the start. Exactly two pops, then a stable head.
      applyStimulus(1'b1, 2'b00, 2'b00, 2'b11);
      fillFifo(0, 32'd100, 10);
      nextCycle();
      applyStimulus(1'b0, 2'b00, 2'b00, 2'b10);
      pops = 0;
      for (int c = 0; c < 6; c++) begin
         #1;
         if (popO[0] === 1'b1) pops++;
         if (c == 5) begin
            checkOutput("t3_occ", 0, 32'(occO[0]), 32'h2);
            checkOutput("t3_valid", 0, 32'(validO[0]), 32'h1);
            checkOutput("t3_head", 0, dataO[0], 32'd100);
         end
         nextCycle();
      end
      checkOutput("t3_pops", 0, 32'(pops), 32'h2);
      applyStimulus(1'b0, 2'b00, 2'b00, 2'b11);
      k = 0;
      for (int c = 0; c < 25; c++) begin
         #1;
         if (validO[0] === 1'b1) begin
            checkOutput("t3_order", 0, dataO[0], 32'd100 + 32'(k));
            k++;
         end
         nextCycle();
      end
      checkOutput("t3_count", 0, 32'(k), 32'd10);

      // Bubbles: the FIFO reports empty on every other cycle.
      doReset();
      fillFifo(0, 32'd200, 20);
      k = 0;
      for (int c = 0; c < 60; c++) begin
         applyStimulus(1'b0, 2'b00, {1'b0, 1'(c % 2)}, 2'b11);
         #1;
         if (c % 2 == 1) checkOutput("t4_nopop", 0, 32'(popO[0]), 32'h0);
         if (validO[0] === 1'b1) begin
            checkOutput("t4_order", 0, dataO[0], 32'd200 + 32'(k));
            k++;
         end
         nextCycle();
      end
      checkOutput("t4_count", 0, 32'(k), 32'd20);

      // Flush on lane 1 (L=2) with two words buffered and one in flight.
      doReset();
      fillFifo(1, 32'd300, 10);
      applyStimulus(1'b0, 2'b00, 2'b00, 2'b01);
      for (int c = 0; c < 9; c++) begin
         if (c == 4) applyStimulus(1'b0, 2'b10, 2'b00, 2'b01);
         if (c == 5) applyStimulus(1'b0, 2'b00, 2'b00, 2'b01);
         #1;
         if (c == 4) begin
            checkOutput("t5_occ_pre", 1, 32'(occO[1]), 32'h2);
            checkOutput("t5_pop_flush", 1, 32'(popO[1]), 32'h0);
         end
         if (c == 5) begin
            checkOutput("t5_valid_post", 1, 32'(validO[1]), 32'h0);
            checkOutput("t5_occ_post", 1, 32'(occO[1]), 32'h0);
            checkOutput("t5_pop_resume", 1, 32'(popO[1]), 32'h1);
         end
         if (c == 8) begin
            checkOutput("t5_valid_next", 1, 32'(validO[1]), 32'h1);
            checkOutput("t5_data_next", 1, dataO[1], 32'd303);
         end
         nextCycle();
      end
      applyStimulus(1'b0, 2'b00, 2'b00, 2'b11);
      k = 0;
      for (int c = 0; c < 25; c++) begin
         #1;
         if (validO[1] === 1'b1) begin
            checkOutput("t5_order", 1, dataO[1], 32'd303 + 32'(k));
            k++;
         end
         nextCycle();
      end
      checkOutput("t5_count", 1, 32'(k), 32'd7);

      // Perf: lane 0 is valid and not ready in cycles 2..6; lane 1 is ready
      // with nothing to send in cycles 0..6.
      doReset();
      fillFifo(0, 32'd400, 4);
      applyStimulus(1'b0, 2'b00, 2'b00, 2'b10);
      for (int c = 0; c < 8; c++) begin
         #1;
         if (c == 7) begin
`ifdef FIFO_READER_PERF_EN
            checkOutput("t6_stall", 0, stallO[0], 32'd5);
            checkOutput("t6_starve", 1, starveO[1], 32'd7);
`else
            checkOutput("t6_stall", 0, stallO[0], 32'd0);
            checkOutput("t6_starve", 1, starveO[1], 32'd0);
`endif
         end
         nextCycle();
      end
      applyStimulus(1'b0, 2'b00, 2'b00, 2'b11);
      repeat (8) nextCycle();

      // Random ready, bubbles and flushes on both lanes, with one reset in
      // the middle of the run.
      fillFifo(0, 32'd500, 80);
      fillFifo(1, 32'd600, 80);
      for (int c = 0; c < 300; c++) begin
         applyStimulus((c == 150) ? 1'b1 : 1'b0,
                       {1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 19) == 0)},
                       {1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0)},
                       {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)});
         nextCycle();
      end
      applyStimulus(1'b0, 2'b00, 2'b00, 2'b11);
      repeat (4) nextCycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
